// File: rtl/scroll_engine_if.sv
// rtl/scroll_engine_if.sv - load/pulse inputs and scrolled-coordinate outputs of the scroll engine
// master drives the load side (jump logic), slave is the engine itself.
interface scroll_engine_if #(
    parameter int W       = 10,
    parameter int N_STAGE = 2,
    parameter int STEP_W  = 3
) ();
    logic                 start;
    logic                 pulse;
    logic [STEP_W-1:0]    step;
    logic [W-1:0]         man_x;
    logic [N_STAGE*W-1:0] stage_x;
    logic                 busy;
    logic                 done;
    logic [W-1:0]         new_man_x;
    logic [N_STAGE*W-1:0] new_stage_x;
    logic [N_STAGE-1:0]   gone;
    logic [7:0]           move_cnt;

    modport master (
        output start, pulse, step, man_x, stage_x,
        input  busy, done, new_man_x, new_stage_x, gone, move_cnt
    );

    modport slave (
        input  start, pulse, step, man_x, stage_x,
        output busy, done, new_man_x, new_stage_x, gone, move_cnt
    );
endinterface

// File: rtl/scroll_engine.sv
// rtl/scroll_engine.sv - camera scroll: shifts player and N stages left until the player reaches TARGET_X
// Optional SCROLL_EASE_EN: step shrinks to max(1, rem>>2) near the target.
module scroll_engine #(
    parameter int W        = 10,
    parameter int N_STAGE  = 2,
    parameter int TARGET_X = 60,
    parameter int STEP_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    scroll_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCROLL, DONE} state_t;

    localparam logic [W-1:0] TGT = W'(TARGET_X);

    state_t               state, state_n;
    logic [W-1:0]         man_q;
    logic [N_STAGE*W-1:0] stage_q;
    logic [W-1:0]         step_q;
    logic [N_STAGE-1:0]   gone_q;
    logic [7:0]           cnt_q;
    logic                 busy_q, done_q;

    logic                 load, do_move, at_target;
    logic [W-1:0]         step_in, rem, lim, s_eff;
    logic [N_STAGE*W-1:0] stage_mv;
    logic [N_STAGE-1:0]   gone_mv;

    always_comb begin
        step_in = W'(bus.step);
        if (step_in == '0) begin
            step_in = W'(1);
        end
    end

    assign at_target = (man_q <= TGT);
    assign rem       = man_q - TGT;

`ifdef SCROLL_EASE_EN
    always_comb begin
        lim = rem >> 2;
        if (lim == '0) begin
            lim = W'(1);
        end
    end
`else
    assign lim = rem;
`endif

    // Clamping to rem means the player can never pass TARGET_X.
    assign s_eff = (step_q < lim) ? step_q : lim;

    always_comb begin
        stage_mv = stage_q;
        gone_mv  = gone_q;
        for (int i = 0; i < N_STAGE; i++) begin
            if (stage_q[i*W +: W] >= s_eff) begin
                stage_mv[i*W +: W] = stage_q[i*W +: W] - s_eff;
            end else begin
                stage_mv[i*W +: W] = '0;
                gone_mv[i]         = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        do_move = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = SCROLL;
                end
            end
            SCROLL: begin
                // Completion check wins over a coincident pulse.
                if (at_target) begin
                    state_n = DONE;
                end else if (bus.pulse) begin
                    do_move = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            man_q   <= '0;
            stage_q <= '0;
            step_q  <= '0;
            gone_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == SCROLL);
            done_q <= (state_n == DONE);
            if (load) begin
                man_q   <= bus.man_x;
                stage_q <= bus.stage_x;
                step_q  <= step_in;
                gone_q  <= '0;
                cnt_q   <= '0;
            end else if (do_move) begin
                man_q   <= man_q - s_eff;
                stage_q <= stage_mv;
                gone_q  <= gone_mv;
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.new_man_x   = man_q;
    assign bus.new_stage_x = stage_q;
    assign bus.gone        = gone_q;
    assign bus.move_cnt    = cnt_q;
endmodule
